// File: rtl/mem_arbiter_if.sv
// Bundle of requester, downstream-memory and status signals for mem_arbiter.
// The arbiter connects through the slave modport; requesters/memory sit on master.
interface mem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [2:0]  m0_size;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [2:0]  m1_size;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_u_b_h_w;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_size,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_size,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write, mem_u_b_h_w, busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_size,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_size,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write, mem_u_b_h_w, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU=0, DMA=1) single-outstanding memory arbiter with IDLE/ISSUE/WAIT FSM.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise port 0 has priority.
module mem_arbiter #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        owner_q;
  logic [1:0]  gnt_q;
  logic [1:0]  rvalid_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [2:0]  mem_size_q;
  logic        busy_q;
`ifdef MEM_ARB_RR_EN
  logic        last_q;
`endif

  logic        any_req_d;
  logic        win_d;
  logic        sel_we_d;
  logic [31:0] sel_addr_d;
  logic [31:0] sel_wdata_d;
  logic [2:0]  sel_size_d;

  // Winner selection and command mux for the IDLE sampling cycle.
  always_comb begin
    any_req_d = bus.m0_req | bus.m1_req;
`ifdef MEM_ARB_RR_EN
    if (bus.m0_req && bus.m1_req) begin
      win_d = ~last_q;
    end else begin
      win_d = ~bus.m0_req;
    end
`else
    if (bus.m0_req) begin
      win_d = 1'b0;
    end else begin
      win_d = 1'b1;
    end
`endif
    if (win_d) begin
      sel_we_d    = bus.m1_we;
      sel_addr_d  = bus.m1_addr;
      sel_wdata_d = bus.m1_wdata;
      sel_size_d  = bus.m1_size;
    end else begin
      sel_we_d    = bus.m0_we;
      sel_addr_d  = bus.m0_addr;
      sel_wdata_d = bus.m0_wdata;
      sel_size_d  = bus.m0_size;
    end
  end

  // Transaction FSM; every output is a register so strobes are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata0_q    <= 32'd0;
      rdata1_q    <= 32'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_size_q  <= 3'd0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      // Strobes and the downstream bus are single-cycle; default them off.
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_size_q  <= 3'd0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            state_q     <= ISSUE;
            busy_q      <= 1'b1;
            owner_q     <= win_d;
            gnt_q       <= win_d ? 2'b10 : 2'b01;
            mem_read_q  <= ~sel_we_d;
            mem_write_q <= sel_we_d;
            mem_addr_q  <= sel_addr_d;
            mem_wdata_q <= sel_wdata_d;
            mem_size_q  <= sel_size_d;
`ifdef MEM_ARB_RR_EN
            last_q      <= win_d;
`endif
          end else begin
            busy_q      <= 1'b0;
          end
        end
        ISSUE: begin
          if (mem_write_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= WAIT;
            cnt_q   <= 4'(RD_LATENCY - 32'd1);
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q           <= IDLE;
            busy_q            <= 1'b0;
            rvalid_q[owner_q] <= 1'b1;
            if (owner_q) begin
              rdata1_q <= bus.mem_rdata;
            end else begin
              rdata0_q <= bus.mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m0_gnt      = gnt_q[0];
  assign bus.m1_gnt      = gnt_q[1];
  assign bus.m0_rvalid   = rvalid_q[0];
  assign bus.m1_rvalid   = rvalid_q[1];
  assign bus.m0_rdata    = rdata0_q;
  assign bus.m1_rdata    = rdata1_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_u_b_h_w = mem_size_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random requesters, a transaction-level reference
// model that predicts grant/rvalid cycles and data, and a decoupled output monitor.
module tb_mem_arbiter;
  localparam int L = 3;

  typedef struct {
    int          cyc;
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
  } cmd_t;

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
  } rv_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } mem_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.RD_LATENCY(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic        req_a   [2];
  logic        we_a    [2];
  logic [31:0] addr_a  [2];
  logic [31:0] wdata_a [2];
  logic [2:0]  size_a  [2];
  logic [31:0] mem_rdata_v;

  assign bus.m0_req    = req_a[0];
  assign bus.m0_we     = we_a[0];
  assign bus.m0_addr   = addr_a[0];
  assign bus.m0_wdata  = wdata_a[0];
  assign bus.m0_size   = size_a[0];
  assign bus.m1_req    = req_a[1];
  assign bus.m1_we     = we_a[1];
  assign bus.m1_addr   = addr_a[1];
  assign bus.m1_wdata  = wdata_a[1];
  assign bus.m1_size   = size_a[1];
  assign bus.mem_rdata = mem_rdata_v;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  cmd_t        cmd_q[$];
  rv_t         rv_q[$];
  mem_t        mem_q[$];
  int          free_cyc  = 0;
  int          busy_from = 0;
  int          last_p    = 1;
  logic [31:0] last_rd [2] = '{32'd0, 32'd0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 1) ? bus.m1_gnt : bus.m0_gnt;
  endfunction

  // Present one command on port p and hold it until that port is granted.
  task automatic issue(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] size);
    int n;
    we_a[p] = we; addr_a[p] = addr; wdata_a[p] = wdata; size_a[p] = size;
    req_a[p] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!gnt_of(p) && n < 300);
    if (!gnt_of(p)) begin
      n_checks++;
      $display("FAIL gnt_timeout: port %0d got no grant expected one within 300 cycles", p);
    end
    req_a[p] = 1'b0;
    addr_a[p] = $urandom; wdata_a[p] = $urandom;
  endtask

  task automatic drive(input int p, input int n, input int prob);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) >= prob) begin
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
      issue(p, 1'($urandom_range(1)), $urandom, $urandom, 3'($urandom_range(7)));
    end
  endtask

  // Reference model: a free arbiter takes the pending request chosen by the policy;
  // a write occupies it for one cycle, a read until its rvalid cycle L+1 later.
  always @(negedge clk) begin
    if (rst_n && cyc >= free_cyc && (req_a[0] || req_a[1])) begin
      int w;
      logic [31:0] v;
      if (req_a[0] && req_a[1]) begin
`ifdef MEM_ARB_RR_EN
        w = 1 - last_p;
`else
        w = 0;
`endif
      end else begin
        w = req_a[1] ? 1 : 0;
      end
      last_p = w;
      cmd_q.push_back('{cyc + 1, w, we_a[w], addr_a[w], wdata_a[w], size_a[w]});
      busy_from = cyc + 1;
      if (we_a[w]) begin
        free_cyc = cyc + 2;
      end else begin
        v = $urandom;
        mem_q.push_back('{cyc + 1 + L, v});
        rv_q.push_back('{cyc + L + 2, w, v});
        free_cyc = cyc + L + 2;
      end
    end
  end

  // Memory: read data valid only in the cycle L after the strobe, junk otherwise.
  always @(posedge clk) begin
    #1;
    if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
      mem_rdata_v = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      mem_rdata_v = $urandom;
    end
  end

  // Monitor: pop expectations whenever the DUT presents a grant/strobe or rvalid.
  always @(negedge clk) begin
    if (rst_n) begin
      cmd_t e;
      rv_t  r;
      if (bus.m0_gnt || bus.m1_gnt || bus.mem_read || bus.mem_write) begin
        if (cmd_q.size() == 0) begin
          check("unexpected_gnt", {bus.m1_gnt, bus.m0_gnt, bus.mem_read, bus.mem_write}, 128'd0);
        end else begin
          e = cmd_q.pop_front();
          check("gnt_cycle", 128'(cyc), 128'(e.cyc));
          check("gnt_strobes", {bus.m1_gnt, bus.m0_gnt, bus.mem_read, bus.mem_write},
                {(e.port == 1) ? 2'b10 : 2'b01, ~e.we, e.we});
          check("cmd_fields", {bus.mem_addr, bus.mem_wdata, bus.mem_u_b_h_w},
                {e.addr, e.wdata, e.size});
        end
      end else begin
        check("bus_zero_outside_issue", {bus.mem_addr, bus.mem_wdata, bus.mem_u_b_h_w}, 128'd0);
        if (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
          e = cmd_q.pop_front();
          check("missed_gnt", 128'd0, 128'(e.cyc));
        end
      end
      if (bus.m0_rvalid || bus.m1_rvalid) begin
        if (rv_q.size() == 0) begin
          check("unexpected_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 128'd0);
        end else begin
          r = rv_q.pop_front();
          check("rvalid_cycle", 128'(cyc), 128'(r.cyc));
          check("rvalid_port", {bus.m1_rvalid, bus.m0_rvalid}, (r.port == 1) ? 2'b10 : 2'b01);
          last_rd[r.port] = r.data;
        end
      end else if (rv_q.size() > 0 && rv_q[0].cyc < cyc) begin
        r = rv_q.pop_front();
        check("missed_rvalid", 128'd0, 128'(r.cyc));
      end
      check("rdata0", bus.m0_rdata, last_rd[0]);
      check("rdata1", bus.m1_rdata, last_rd[1]);
      check("busy", bus.busy, (cyc >= busy_from && cyc < free_cyc) ? 1'b1 : 1'b0);
    end
  end

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((cmd_q.size() > 0 || rv_q.size() > 0 || cyc < free_cyc) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("drain_cmd_q", 128'(cmd_q.size()), 128'd0);
    check("drain_rv_q", 128'(rv_q.size()), 128'd0);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      req_a[p] = 1'b0; we_a[p] = 1'b0; addr_a[p] = 32'd0; wdata_a[p] = 32'd0; size_a[p] = 3'd0;
    end
    mem_rdata_v = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
                            bus.mem_read, bus.mem_write, bus.busy}, 128'd0);
    check("reset_rdata", {bus.m0_rdata, bus.m1_rdata}, 128'd0);
    rst_n = 1'b1;

    issue(0, 1'b0, 32'h1000_0004, 32'd0, 3'b010);
    issue(1, 1'b1, 32'h3000_0010, 32'h00FF_00FF, 3'b010);
    wait_quiet();
    fork
      drive(0, 4, 100);
      drive(1, 4, 100);
    join
    wait_quiet();
    fork
      drive(0, 40, 60);
      drive(1, 40, 60);
    join
    wait_quiet();

    // Abort a read mid-WAIT with an asynchronous reset.
    issue(1, 1'b0, 32'h2000_0000, 32'd0, 3'b010);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
                                  bus.mem_read, bus.mem_write, bus.busy}, 128'd0);
    check("async_reset_bus", {bus.mem_addr, bus.mem_wdata, bus.mem_u_b_h_w}, 128'd0);
    check("async_reset_rdata", {bus.m0_rdata, bus.m1_rdata}, 128'd0);
    cmd_q.delete(); rv_q.delete(); mem_q.delete();
    free_cyc = 0; busy_from = 0; last_p = 1;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    fork
      drive(0, 3, 100);
      drive(1, 3, 100);
    join
    wait_quiet();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, cycles from mem_read strobe to valid rdata (legal 1..15).
REQ-002 SHALL have ports: clk  in  1  system clock, rising-edge; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have, per requester N in {0,1} (0 = CPU, 1 = DMA): mN_req in 1 request; mN_we in 1 1=write; mN_addr in 32 byte address; mN_wdata in 32 write data; mN_size in 3 mem_u_b_h_w encoding.
REQ-004 SHALL have, per requester N: mN_gnt out 1 command-accepted pulse; mN_rvalid out 1 read-data pulse; mN_rdata out 32 read data.
REQ-005 SHALL have downstream: mem_addr out 32; mem_wdata out 32; mem_read out 1; mem_write out 1; mem_u_b_h_w out 3; mem_rdata in 32; busy out 1 (state != IDLE).

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT; exactly one transaction in flight.
REQ-007 In IDLE with any mN_req=1: SHALL select a winner (REQ-015), latch its we/addr/wdata/size and owner id, go to ISSUE next cycle.
REQ-008 In IDLE with no request: SHALL stay in IDLE with all downstream strobes low.
REQ-009 In ISSUE: SHALL drive latched command on mem_addr/mem_wdata/mem_u_b_h_w, assert mem_read (we=0) or mem_write (we=1) for exactly one cycle, and pulse owner's mN_gnt in the same cycle.
REQ-010 After ISSUE with write: SHALL return to IDLE; write throughput one per 2 cycles.
REQ-011 After ISSUE with read: SHALL enter WAIT, load counter with RD_LATENCY-1, decrement each cycle; at counter 0 SHALL register mem_rdata into owner's mN_rdata, pulse owner's mN_rvalid one cycle later, and return to IDLE in that cycle.
REQ-012 Read completion: mN_rvalid SHALL be high exactly RD_LATENCY+1 cycles after the mN_gnt cycle; non-owner rvalid stays 0.
REQ-013 mN_rdata SHALL hold its last value until the next read completion for that port.
REQ-014 Requester SHALL hold req and command stable until gnt; commands are sampled only in IDLE, changes after latching SHALL NOT affect the in-flight transaction.
REQ-015 Arbitration: single requester wins; simultaneous requests resolved per REQ-020/021.
REQ-016 A request arriving in ISSUE/WAIT SHALL wait; it is considered on the next IDLE cycle (including the cycle rvalid pulses).
REQ-017 mem_addr/mem_wdata/mem_u_b_h_w SHALL be 0 outside ISSUE.

Reset
REQ-018 rst_n=0 SHALL asynchronously force state IDLE, counter 0, all gnt/rvalid/mem_read/mem_write/busy 0, mN_rdata 0, mem_addr/mem_wdata/mem_u_b_h_w 0, last-grant pointer = port 1.
REQ-019 Reset during ISSUE or WAIT SHALL abort the transaction: no gnt (if not yet issued) and no rvalid afterwards; requester re-requests.

Configuration
REQ-020 With MEM_ARB_RR_EN defined: simultaneous requests SHALL be granted to the port not granted most recently (pointer updated on each ISSUE); after reset port 0 wins first.
REQ-021 Without MEM_ARB_RR_EN: port 0 SHALL always win simultaneous requests; last-grant pointer SHALL NOT be synthesised.

Verification
REQ-022 RD_LATENCY=1; m0 read addr 0x1000_0004 size 3'b010, mem_rdata=0xDEADBEEF -> mem_read high cycle 2, m0_gnt cycle 2, m0_rvalid cycle 4 with m0_rdata=0xDEADBEEF.
REQ-023 m1 write addr 0x3000_0010 wdata 0x00FF00FF size 3'b010 -> mem_write one cycle, mem_addr/mem_wdata match, m1_gnt same cycle, no rvalid, busy low next cycle.
REQ-024 Both req held for 4 transactions: with MEM_ARB_RR_EN grants 0,1,0,1; without, grants 0,0,0,0 and m1 starved.
REQ-025 RD_LATENCY=3; m1 read -> m1_rvalid exactly 4 cycles after m1_gnt; m0 request raised during WAIT granted in first IDLE cycle after.
REQ-026 rst_n pulsed low mid-WAIT -> all outputs 0 immediately, no m*_rvalid after release, next request served normally.
